// File: rtl/display_pkg.sv
// Shared constants and types for the display scanner: glyph type, digit
// count and the index width used to address the six digit slots.
package display_pkg;

    localparam int DIGITS = 6;
    localparam int SEG_W  = 7;
    localparam int IDX_W  = 3;

    typedef logic [SEG_W-1:0] glyph_t;

    // All segments dark; active-high segment encoding.
    localparam glyph_t BLANK_GLYPH = '0;

    // One-hot digit enable for a slot index.
    function automatic logic [DIGITS-1:0] onehot_sel(input logic [IDX_W-1:0] idx);
        return DIGITS'(1) << idx;
    endfunction

endpackage

// File: rtl/display_scanner_if.sv
// Bundle between the ALU glyph producers and the scanner.
// load is a single-cycle strobe with no ready: whenever load is high on a
// clock edge, display0..display5 are sampled that same edge; the scanner
// always accepts (a later load simply replaces an undisplayed earlier one).
interface display_scanner_if;
    import display_pkg::*;

    logic              en;
    logic              load;
    glyph_t            display0;
    glyph_t            display1;
    glyph_t            display2;
    glyph_t            display3;
    glyph_t            display4;
    glyph_t            display5;
    glyph_t            seg;
    logic [DIGITS-1:0] digit_sel;
    logic              frame_done;

    modport master (
        output en, load, display0, display1, display2, display3, display4, display5,
        input  seg, digit_sel, frame_done
    );

    modport slave (
        input  en, load, display0, display1, display2, display3, display4, display5,
        output seg, digit_sel, frame_done
    );

endinterface

// File: rtl/display_scanner_prescaler.sv
// Slot prescaler: cnt walks the cycles within a digit slot, idx walks the
// slots within a frame. Both freeze while i_en is low.
module scan_prescaler
    import display_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_boundary
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic             w_tick;

    // End of a slot: only while scanning is enabled.
    assign w_tick     = i_en && (r_cnt == CNT_LAST);
    assign o_boundary = w_tick && (r_idx == IDX_LAST);
    assign o_cnt      = r_cnt;
    assign o_idx      = r_idx;

    // Advance cycle counter, wrapping into the next slot on tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
            r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/display_scanner.sv
// Six-digit multiplexed display driver. New glyphs are staged on load and
// promoted to the displayed set only at a frame boundary, so a frame never
// mixes old and new data. Each slot starts with BLANK_CYC dark cycles to
// suppress ghosting when the segment bus switches digits.
module display_scanner
    import display_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 500
) (
    input  logic              clk,
    input  logic              reset,
    display_scanner_if.slave  bus
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] BLANK_CNT = CNT_W'(BLANK_CYC);

    logic [CNT_W-1:0]  w_cnt;
    logic [IDX_W-1:0]  w_idx;
    logic              w_boundary;
    logic              w_lit;
    glyph_t            w_inputs [DIGITS];

    glyph_t            r_staging [DIGITS];
    glyph_t            r_active  [DIGITS];
    logic              r_pending;
    glyph_t            r_seg;
    logic [DIGITS-1:0] r_digit_sel;
    logic              r_frame_done;

    scan_prescaler #(
        .REFRESH_DIV (REFRESH_DIV),
        .CNT_W       (CNT_W)
    ) u_prescaler (
        .clk        (clk),
        .reset      (reset),
        .i_en       (bus.en),
        .o_cnt      (w_cnt),
        .o_idx      (w_idx),
        .o_boundary (w_boundary)
    );

    assign w_inputs[0] = bus.display0;
    assign w_inputs[1] = bus.display1;
    assign w_inputs[2] = bus.display2;
    assign w_inputs[3] = bus.display3;
    assign w_inputs[4] = bus.display4;
    assign w_inputs[5] = bus.display5;

    // Digit is lit only while scanning and past the blanking window.
    assign w_lit = bus.en && (w_cnt >= BLANK_CNT);

    // Capture: a load on the boundary goes straight to the display; otherwise
    // a pending staged set is promoted at the boundary.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= 1'b0;
            for (int i = 0; i < DIGITS; i++) begin
                r_staging[i] <= BLANK_GLYPH;
                r_active[i]  <= BLANK_GLYPH;
            end
        end else if (bus.load && w_boundary) begin
            r_pending <= 1'b0;
            for (int i = 0; i < DIGITS; i++) r_active[i] <= w_inputs[i];
        end else if (w_boundary && r_pending) begin
            r_pending <= 1'b0;
            for (int i = 0; i < DIGITS; i++) r_active[i] <= r_staging[i];
        end else if (bus.load) begin
            r_pending <= 1'b1;
            for (int i = 0; i < DIGITS; i++) r_staging[i] <= w_inputs[i];
        end
    end

    // Registered output stage: one cycle behind the counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_seg        <= BLANK_GLYPH;
            r_digit_sel  <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_seg        <= w_lit ? r_active[w_idx] : BLANK_GLYPH;
            r_digit_sel  <= w_lit ? onehot_sel(w_idx) : '0;
            r_frame_done <= w_boundary;
        end
    end

    assign bus.seg        = r_seg;
    assign bus.digit_sel  = r_digit_sel;
    assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_display_scanner.sv
// Bench for display_scanner with REFRESH_DIV=4, BLANK_CYC=1.
module tb_display_scanner;
    import display_pkg::*;

    localparam int RDIV  = 4;
    localparam int BLANK = 1;
    localparam int FRAME = DIGITS * RDIV;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    display_scanner_if bus ();

    display_scanner #(
        .REFRESH_DIV (RDIV),
        .BLANK_CYC   (BLANK)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- bookkeeping ----------------
    int checks   = 0;
    int failures = 0;
    logic [13:0] exp_q[$];

    glyph_t d [DIGITS];

    // reference model state: m_pos is the position within the frame
    int     m_pos;
    bit     m_pend;
    glyph_t m_stage [DIGITS];
    glyph_t m_act   [DIGITS];

    // observation records
    int                step_no     = 0;
    int                fd_cnt      = 0;
    int                last_fd     = -1000;
    int                last_period = 0;
    int                sel_cnt   [DIGITS];
    bit                seen      [DIGITS];
    glyph_t            first_seg [DIGITS];
    glyph_t            watch       = '0;
    int                watch_hits  = 0;
    logic [DIGITS-1:0] last_sel;
    glyph_t            last_seg;
    logic              last_fd_bit;

    typedef struct {
        int     n;
        bit     rst;
        bit     en;
        bit     ld;
        glyph_t d0;
        glyph_t d1;
        int     exp_fd;
        glyph_t exp_g0;
        glyph_t exp_g1;
        int     exp_lit;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s step=%0d got=%0h expected=%0h", name, step_no, got, want);
        end
    endtask

    task automatic clear_rec();
        for (int i = 0; i < DIGITS; i++) begin
            sel_cnt[i]   = 0;
            seen[i]      = 1'b0;
            first_seg[i] = '0;
        end
        watch_hits = 0;
    endtask

    // ---------------- driver + scoreboard step ----------------
    task automatic step(input bit rst, input bit e, input bit ld);
        logic [13:0]       exp_v;
        logic [13:0]       got_v;
        logic [13:0]       want;
        logic [DIGITS-1:0] es;
        glyph_t            eg;
        bit                bnd;
        bit                lit;
        int                mc;
        int                mi;
        @(negedge clk);
        step_no++;
        reset        = rst;
        bus.en       = e;
        bus.load     = ld;
        bus.display0 = d[0];
        bus.display1 = d[1];
        bus.display2 = d[2];
        bus.display3 = d[3];
        bus.display4 = d[4];
        bus.display5 = d[5];

        mc  = m_pos % RDIV;
        mi  = m_pos / RDIV;
        bnd = e && (m_pos == FRAME - 1);
        lit = e && (mc >= BLANK);
        es  = lit ? (DIGITS'(1) << mi) : '0;
        eg  = lit ? m_act[mi] : '0;
        exp_v = rst ? 14'd0 : {bnd, es, eg};
        exp_q.push_back(exp_v);

        if (rst) begin
            m_pos  = 0;
            m_pend = 1'b0;
            for (int i = 0; i < DIGITS; i++) begin
                m_stage[i] = '0;
                m_act[i]   = '0;
            end
        end else begin
            if (ld && bnd) begin
                for (int i = 0; i < DIGITS; i++) m_act[i] = d[i];
                m_pend = 1'b0;
            end else if (bnd && m_pend) begin
                for (int i = 0; i < DIGITS; i++) m_act[i] = m_stage[i];
                m_pend = 1'b0;
            end else if (ld) begin
                for (int i = 0; i < DIGITS; i++) m_stage[i] = d[i];
                m_pend = 1'b1;
            end
            if (e) m_pos = (m_pos == FRAME - 1) ? 0 : m_pos + 1;
        end

        @(posedge clk);
        #1;
        got_v       = {bus.frame_done, bus.digit_sel, bus.seg};
        last_sel    = bus.digit_sel;
        last_seg    = bus.seg;
        last_fd_bit = bus.frame_done;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty step=%0d got=%0h expected=entry", step_no, got_v);
        end else begin
            want = exp_q.pop_front();
            check("cycle_outputs", got_v, want);
        end

        for (int i = 0; i < DIGITS; i++) begin
            if (bus.digit_sel[i]) begin
                sel_cnt[i]++;
                if (!seen[i]) begin
                    seen[i]      = 1'b1;
                    first_seg[i] = bus.seg;
                end
            end
        end
        if (bus.frame_done) begin
            fd_cnt++;
            last_period = step_no - last_fd;
            last_fd     = step_no;
        end
        if (watch != '0 && bus.seg == watch) watch_hits++;
    endtask

    task automatic run_until_pos(input int target, input int bound);
        int k;
        k = 0;
        while (m_pos != target && k < bound) begin
            step(1'b0, 1'b1, 1'b0);
            k++;
        end
        check("reach_pos_timeout", 32'(m_pos == target), 32'd1);
    endtask

    task automatic wait_fd(input int bound);
        int k;
        int start;
        k     = 0;
        start = fd_cnt;
        while (fd_cnt == start && k < bound) begin
            step(1'b0, 1'b1, 1'b0);
            k++;
        end
        check("frame_done_timeout", 32'(fd_cnt != start), 32'd1);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        bus.en = 1'b0; bus.load = 1'b0;
        bus.display0 = '0; bus.display1 = '0; bus.display2 = '0;
        bus.display3 = '0; bus.display4 = '0; bus.display5 = '0;
        for (int i = 0; i < DIGITS; i++) d[i] = '0;
        m_pos = 0; m_pend = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            m_stage[i] = '0;
            m_act[i]   = '0;
        end
        clear_rec();

        // n, rst, en, ld, d0, d1, frame_done pulses, digit0/1 first lit glyph, lit cycles per digit (-1 skip)
        tbl[0] = '{2,  1'b1, 1'b1, 1'b0, 7'h00, 7'h00, 0, 7'h00, 7'h00, 0};
        tbl[1] = '{48, 1'b0, 1'b1, 1'b0, 7'h00, 7'h00, 2, 7'h00, 7'h00, 6};
        tbl[2] = '{10, 1'b0, 1'b1, 1'b0, 7'h00, 7'h00, 0, 7'h00, 7'h00, -1};
        tbl[3] = '{1,  1'b0, 1'b1, 1'b1, 7'h3F, 7'h06, 0, 7'h00, 7'h00, -1};
        tbl[4] = '{13, 1'b0, 1'b1, 1'b0, 7'h3F, 7'h06, 1, 7'h00, 7'h00, -1};
        tbl[5] = '{24, 1'b0, 1'b1, 1'b0, 7'h3F, 7'h06, 1, 7'h3F, 7'h06, 3};

        for (int r = 0; r < 6; r++) begin
            d[0]   = tbl[r].d0;
            d[1]   = tbl[r].d1;
            fd_cnt = 0;
            clear_rec();
            for (int k = 0; k < tbl[r].n; k++) step(tbl[r].rst, tbl[r].en, tbl[r].ld);
            check($sformatf("row%0d_frame_done_count", r), 32'(fd_cnt), 32'(tbl[r].exp_fd));
            check($sformatf("row%0d_digit0_glyph", r), 32'(first_seg[0]), 32'(tbl[r].exp_g0));
            check($sformatf("row%0d_digit1_glyph", r), 32'(first_seg[1]), 32'(tbl[r].exp_g1));
            if (tbl[r].exp_lit >= 0) begin
                for (int i = 0; i < DIGITS; i++)
                    check($sformatf("row%0d_lit_cycles_d%0d", r, i), 32'(sel_cnt[i]), 32'(tbl[r].exp_lit));
            end
        end
        check("frame_period_free_run", 32'(last_period), 32'(FRAME));

        // Two loads in one frame: the last one wins, the first never shows.
        repeat (3) step(1'b0, 1'b1, 1'b0);
        d[0] = 7'h3F;
        step(1'b0, 1'b1, 1'b1);
        repeat (4) step(1'b0, 1'b1, 1'b0);
        d[0] = 7'h5B;
        step(1'b0, 1'b1, 1'b1);
        wait_fd(30);
        clear_rec();
        watch = 7'h3F;
        repeat (FRAME) step(1'b0, 1'b1, 1'b0);
        check("double_load_digit0", 32'(first_seg[0]), 32'h5B);
        check("double_load_old_glyph_hits", 32'(watch_hits), 32'd0);
        watch = '0;

        // Load exactly on the boundary cycle goes straight to the display.
        run_until_pos(FRAME - 1, 30);
        d[0] = 7'h4F;
        step(1'b0, 1'b1, 1'b1);
        check("boundary_load_frame_done", 32'(last_fd_bit), 32'd1);
        check("boundary_load_pending", 32'(dut.r_pending), 32'd0);
        clear_rec();
        repeat (FRAME) step(1'b0, 1'b1, 1'b0);
        check("boundary_load_digit0", 32'(first_seg[0]), 32'h4F);
        clear_rec();
        repeat (FRAME) step(1'b0, 1'b1, 1'b0);
        check("boundary_load_digit0_next", 32'(first_seg[0]), 32'h4F);

        // Enable dropped for 10 cycles mid-slot.
        repeat (5) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("en_low_digit_sel", 32'(last_sel), 32'd0);
        check("en_low_seg", 32'(last_seg), 32'd0);
        repeat (9) step(1'b0, 1'b0, 1'b0);
        wait_fd(60);
        check("en_low_frame_period", 32'(last_period), 32'(FRAME + 10));

        // Reset mid-frame with a load pending.
        d[0] = 7'h11;
        run_until_pos(10, 30);
        step(1'b0, 1'b1, 1'b1);
        repeat (2) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("midreset_digit_sel", 32'(last_sel), 32'd0);
        check("midreset_seg", 32'(last_seg), 32'd0);
        check("midreset_frame_done", 32'(last_fd_bit), 32'd0);
        clear_rec();
        fd_cnt = 0;
        watch  = 7'h11;
        repeat (2 * FRAME) step(1'b0, 1'b1, 1'b0);
        check("midreset_pending_hits", 32'(watch_hits), 32'd0);
        check("midreset_digit0", 32'(first_seg[0]), 32'h00);
        check("midreset_frame_count", 32'(fd_cnt), 32'd2);
        watch = '0;

        // Random traffic against the reference model.
        for (int k = 0; k < 300; k++) begin
            bit rr;
            bit ee;
            bit ll;
            rr = ($urandom_range(0, 99) == 0);
            ee = ($urandom_range(0, 9) != 0);
            ll = ($urandom_range(0, 5) == 0);
            if (ll) begin
                for (int i = 0; i < DIGITS; i++) d[i] = 7'($urandom_range(0, 127));
            end
            step(rr, ee, ll);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
